// File: rtl/ack_return_sync_pkg.sv
// Shared definitions for the ack/req return path: FSM state encoding and synchroniser depth limits.
package ack_return_sync_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    ACKED    = 2'd2,
    WAIT_REL = 2'd3
  } hs_state_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  function automatic bit sync_stages_legal(input int n);
    return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/ack_return_sync_sync_ff.sv
// sync_ff_chain: STAGES-deep single-bit synchroniser, async active-high reset to 0.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/ack_return_sync.sv
// Master-side receiver for the arbiter ack: synchronises ack_src, closes the 4-phase handshake.
// Optional ACK_TIMEOUT_EN adds a WAIT_ACK watchdog driving timeout_err.
module ack_return_sync
  import ack_return_sync_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_in,
  input  logic             ack_src,
  input  logic             err_clr,
  output logic             ack_out,
  output logic             proto_err,
  output logic             timeout_err,
  output logic [CNT_W-1:0] txn_count
);

  if (!sync_stages_legal(SYNC_STAGES) || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("ack_return_sync: illegal SYNC_STAGES or TIMEOUT_CYCLES");
  end

  hs_state_t state, state_n;
  logic      ack_sync;
  logic      proto_set, txn_inc, primed;
  logic [SYNC_STAGES-1:0] vld_pipe;

  sync_ff_chain #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack_src),
    .q   (ack_sync)
  );

  // ack_sync reads 0 until the chain has refilled after reset; holding WAIT_REL until
  // then keeps a stale high ack from being mistaken for a release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
  end
  assign primed = vld_pipe[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_REL;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    proto_set = 1'b0;
    txn_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_in) state_n = WAIT_ACK;
        else if (ack_sync) begin
          proto_set = 1'b1;
          state_n   = WAIT_REL;
        end
      end
      WAIT_ACK: begin
        if (ack_sync)     state_n = ACKED;
        else if (!req_in) state_n = WAIT_REL;
      end
      ACKED: begin
        if (!req_in) begin
          txn_inc = 1'b1;
          state_n = ack_sync ? WAIT_REL : IDLE;
        end
      end
      WAIT_REL: begin
        if (!ack_sync && primed) state_n = IDLE;
      end
      default: state_n = WAIT_REL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_out   <= 1'b0;
      proto_err <= 1'b0;
      txn_count <= '0;
    end else begin
      ack_out <= (state_n == ACKED);
      if (err_clr)        proto_err <= 1'b0;
      else if (proto_set) proto_err <= 1'b1;
      if (txn_inc) txn_count <= txn_count + CNT_W'(1);
    end
  end

`ifdef ACK_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer;
  logic          to_set;

  assign to_set = (state == WAIT_ACK) && (timer == T_LAST);

  // Timer saturates at T_LAST; the FSM keeps waiting, only the flag reports it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == WAIT_ACK && state_n == WAIT_ACK)
        timer <= to_set ? timer : timer + 1'b1;
      else
        timer <= '0;
      if (err_clr)     timeout_err <= 1'b0;
      else if (to_set) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ack_return_sync.sv
// Directed bench for ack_return_sync: vector table plus handshake, wrap, reset and timeout sequences.
module tb_ack_return_sync;

  logic clk = 1'b0;
  logic rst, req_in, ack_src, err_clr;
  logic ack_out, proto_err, timeout_err;
  logic [15:0] txn_count;
  logic ack_out_w, proto_err_w, timeout_err_w;
  logic [3:0] txn_count_w;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  ack_return_sync #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .ack_src(ack_src), .err_clr(err_clr),
    .ack_out(ack_out), .proto_err(proto_err), .timeout_err(timeout_err), .txn_count(txn_count)
  );

  // Narrow counter copy shares all inputs, so its count must be the low 4 bits.
  ack_return_sync #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(16), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .req_in(req_in), .ack_src(ack_src), .err_clr(err_clr),
    .ack_out(ack_out_w), .proto_err(proto_err_w), .timeout_err(timeout_err_w),
    .txn_count(txn_count_w)
  );

  typedef struct {
    int req, ack, clr, e_ack, e_perr, e_cnt;
  } vec_t;

  vec_t tbl [39];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic a, input logic c);
    @(negedge clk);
    req_in = r; ack_src = a; err_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic handshake(input bit chk_lat);
    int n;
    n = 0;
    do begin
      step(1'b1, 1'b1, 1'b0);
      n++;
    end while (!ack_out && n < 10);
    chk("hs_ack_seen", ack_out, 1);
    if (chk_lat) chk("ack_latency_edges", n, 3);
    step(1'b0, 1'b0, 1'b0);
    exp_cnt++;
    chk("hs_ack_drop", ack_out, 0);
    chk("hs_count", txn_count, exp_cnt);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{
      '{0,0,0, 0,0,0}, '{0,0,0, 0,0,0}, '{0,0,0, 0,0,0},
      '{1,0,0, 0,0,0}, '{1,1,0, 0,0,0}, '{1,1,0, 0,0,0}, '{1,1,0, 1,0,0},
      '{0,1,0, 0,0,1}, '{0,0,0, 0,0,1}, '{0,0,0, 0,0,1}, '{0,0,0, 0,0,1},
      '{0,1,0, 0,0,1}, '{0,1,0, 0,0,1}, '{0,1,0, 0,1,1},
      '{1,0,0, 0,1,1}, '{1,0,1, 0,0,1}, '{1,0,0, 0,0,1},
      '{1,0,0, 0,0,1}, '{1,0,0, 0,0,1}, '{0,0,0, 0,0,1}, '{0,0,0, 0,0,1},
      '{1,1,0, 0,0,1}, '{1,1,0, 0,0,1}, '{1,1,0, 1,0,1},
      '{0,0,0, 0,0,2}, '{0,0,0, 0,0,2}, '{0,0,0, 0,0,2},
      '{1,1,0, 0,0,2}, '{1,0,0, 0,0,2}, '{1,0,0, 1,0,2},
      '{0,0,0, 0,0,3}, '{0,0,0, 0,0,3},
      '{0,1,0, 0,0,3}, '{0,1,0, 0,0,3}, '{0,1,1, 0,0,3},
      '{0,0,0, 0,0,3}, '{0,0,0, 0,0,3}, '{0,0,0, 0,0,3}, '{0,0,0, 0,0,3}
    };

    rst = 1'b1; req_in = 1'b0; ack_src = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack_out", ack_out, 0);
    chk("reset_proto_err", proto_err, 0);
    chk("reset_timeout_err", timeout_err, 0);
    chk("reset_txn_count", txn_count, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].req[0], tbl[i].ack[0], tbl[i].clr[0]);
      chk($sformatf("vec%0d_ack_out", i), ack_out, tbl[i].e_ack);
      chk($sformatf("vec%0d_proto_err", i), proto_err, tbl[i].e_perr);
      chk($sformatf("vec%0d_txn_count", i), txn_count, tbl[i].e_cnt);
      chk($sformatf("vec%0d_timeout_err", i), timeout_err, 0);
    end
    exp_cnt = 3;

    // Back-to-back handshakes, first one also checks ack latency.
    for (int k = 0; k < 5; k++) handshake(k == 0);
    chk("b2b_count", txn_count, 8);
    chk("b2b_proto_err", proto_err, 0);
    chk("b2b_timeout_err", timeout_err, 0);

    // Drive the narrow counter through its wrap: 20 total -> 4 in 4 bits.
    for (int k = 0; k < 12; k++) handshake(1'b0);
    chk("wide_count", txn_count, 20);
    chk("wrap_count", txn_count_w, 4);

    // Reset while ACKED with ack still high.
    n_checks = n_checks;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0);
    chk("pre_rst_acked", ack_out, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ack_out", ack_out, 0);
    chk("rst_async_count", txn_count, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 1'b0);
      chk($sformatf("stale_ack_ignored%0d", k), ack_out, 0);
      chk($sformatf("stale_ack_perr%0d", k), proto_err, 0);
    end
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
    handshake(1'b0);
    chk("post_rst_count", txn_count, 1);

    // Long wait for ack: timeout flag only with the watchdog compiled in.
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 1'b0);
`ifdef ACK_TIMEOUT_EN
      chk($sformatf("timeout_wait%0d", k), timeout_err, (k >= 16) ? 1 : 0);
`else
      chk($sformatf("timeout_wait%0d", k), timeout_err, 0);
`endif
      chk($sformatf("timeout_no_ack%0d", k), ack_out, 0);
    end
    handshake(1'b0);
    chk("late_ack_count", txn_count, 2);
`ifdef ACK_TIMEOUT_EN
    chk("timeout_sticky", timeout_err, 1);
`else
    chk("timeout_off", timeout_err, 0);
`endif
    step(1'b0, 1'b0, 1'b1);
    chk("timeout_cleared", timeout_err, 0);
    step(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
